// File: rtl/state_sequencer.sv
// -----------------------------------------------------------------------------
// state_sequencer
//   Multi-cycle instruction control sequencer. It accepts one opcode at a time
//   from fetch and steps through RegsWrite / MemtoRegs / MemWrite before a
//   single PCWrite cycle, then returns to IDLE. Memory states wait on memReady,
//   with a bounded wait that forces an exit.
//
// Parameters
//   MEM_TIMEOUT   maximum wait cycles in a memory state before forced exit
//                 (1..255)
//
// Ports
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   opcode[6:0]    in   instruction opcode, sampled only on accept
//   instrValid     in   fetch presents a valid opcode
//   instrReady     out  sequencer is in IDLE and can accept an opcode
//   memReady       in   data memory completes the current access
//   state[2:0]     out  registered control state
//   pcWriteEnable  out  PC update strobe, high only during PCWrite
//   illegalInstr   out  one-cycle pulse, coincident with PCWrite, for an
//                       unsupported opcode
//   memTimeout     out  one-cycle pulse, coincident with PCWrite, when the
//                       memory wait expired
//   retiredCount   out  number of completed PCWrite cycles (wraps)
// -----------------------------------------------------------------------------
module state_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        instrValid,
  output logic        instrReady,
  input  logic        memReady,
  output logic [2:0]  state,
  output logic        pcWriteEnable,
  output logic        illegalInstr,
  output logic        memTimeout,
  output logic [15:0] retiredCount
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REGSWRITE = 3'd1;
  localparam logic [2:0] MEMTOREGS = 3'd2;
  localparam logic [2:0] MEMWRITE  = 3'd3;
  localparam logic [2:0] PCWRITE   = 3'd4;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [7:0]  wait_cnt;
  logic        illegal_d;
  logic        timeout_d;
  logic        accept;
  logic        in_mem;
  logic [15:0] retired_count;

  // Target state for an accepted opcode. Branches and unsupported opcodes
  // both go straight to PCWrite.
  function automatic logic [2:0] decode_opcode(input logic [6:0] op);
    logic [2:0] nxt;
    case (op)
      7'b0000011: nxt = MEMTOREGS;
      7'b0100011: nxt = MEMWRITE;
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111,
      7'b1101111,
      7'b1100111: nxt = REGSWRITE;
      default:    nxt = PCWRITE;
    endcase
    return nxt;
  endfunction

  // An opcode that decodes to PCWrite but is not a branch is unsupported.
  function automatic logic is_illegal(input logic [6:0] op);
    return (decode_opcode(op) == PCWRITE) && (op != 7'b1100011);
  endfunction

  assign instrReady    = (state_q == IDLE);
  assign accept        = instrValid && instrReady;
  assign in_mem        = (state_q == MEMTOREGS) || (state_q == MEMWRITE);
  assign state         = state_q;
  assign pcWriteEnable = (state_q == PCWRITE);
  assign retiredCount  = retired_count;

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = decode_opcode(opcode);
          illegal_d = is_illegal(opcode);
        end
      end
      REGSWRITE: state_d = PCWRITE;
      MEMTOREGS, MEMWRITE: begin
        // A completing access takes priority over an expiring wait, so a
        // same-cycle memReady never raises memTimeout.
        if (memReady) begin
          state_d = PCWRITE;
        end else if (wait_cnt >= TIMEOUT_LIMIT) begin
          state_d   = PCWRITE;
          timeout_d = 1'b1;
        end
      end
      PCWRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt      <= 8'd0;
      illegalInstr  <= 1'b0;
      memTimeout    <= 1'b0;
      retired_count <= 16'd0;
    end else begin
      state_q      <= state_d;
      illegalInstr <= illegal_d;
      memTimeout   <= timeout_d;
      // The counter only runs while a memory state is held, so every entry
      // into a memory state starts from zero.
      if (in_mem && (state_d == state_q)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (state_q == PCWRITE) begin
        retired_count <= retired_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
module tb_state_sequencer;

  localparam int unsigned MEM_TIMEOUT = 15;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_ILL   = 4;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        instrValid;
  logic        instrReady;
  logic        memReady;
  logic [2:0]  state;
  logic        pcWriteEnable;
  logic        illegalInstr;
  logic        memTimeout;
  logic [15:0] retiredCount;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  state_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .memReady     (memReady),
    .state        (state),
    .pcWriteEnable(pcWriteEnable),
    .illegalInstr (illegalInstr),
    .memTimeout   (memTimeout),
    .retiredCount (retiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return K_ALU;
      7'b1100011: return K_BR;
      default:    return K_ILL;
    endcase
  endfunction

  // Reference model: tracks the one instruction in flight by its kind and its
  // age in cycles since accept. pc_age is the age at which PCWrite is shown;
  // for memory instructions it stays 0 until the access ends or expires.
  bit          started = 0;
  bit          busy = 0;
  int          kind = 0;
  int          age = 0;
  int          pc_age = 0;
  logic [2:0]  m_state = 3'd0;
  logic        m_ill = 1'b0;
  logic        m_to = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  always @(posedge clk) begin
    cycle++;
    m_ill = 1'b0;
    m_to  = 1'b0;
    if (reset) begin
      started = 1;
      busy    = 0;
      m_state = 3'd0;
      m_cnt   = 16'd0;
    end else begin
      if (m_state == 3'd4) m_cnt = m_cnt + 16'd1;
      if (!busy) begin
        if (instrValid) begin
          kind   = classify(opcode);
          busy   = 1;
          age    = 1;
          pc_age = (kind == K_ALU) ? 2 : ((kind == K_LOAD || kind == K_STORE) ? 0 : 1);
          m_ill  = (kind == K_ILL);
        end
      end else begin
        if ((kind == K_LOAD || kind == K_STORE) && pc_age == 0) begin
          // age-1 cycles have already been waited in the memory state
          if (memReady) begin
            pc_age = age + 1;
          end else if (age - 1 >= int'(MEM_TIMEOUT)) begin
            pc_age = age + 1;
            m_to   = 1'b1;
          end
        end
        age++;
        if (pc_age != 0 && age > pc_age) busy = 0;
      end
      if (!busy)                m_state = 3'd0;
      else if (age == pc_age)   m_state = 3'd4;
      else if (kind == K_ALU)   m_state = 3'd1;
      else if (kind == K_LOAD)  m_state = 3'd2;
      else                      m_state = 3'd3;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_state", {13'd0, state}, {13'd0, m_state});
      chk("m_instrReady", {15'd0, instrReady}, {15'd0, (m_state == 3'd0)});
      chk("m_pcWriteEnable", {15'd0, pcWriteEnable}, {15'd0, (m_state == 3'd4)});
      chk("m_illegalInstr", {15'd0, illegalInstr}, {15'd0, m_ill});
      chk("m_memTimeout", {15'd0, memTimeout}, {15'd0, m_to});
      chk("m_retiredCount", retiredCount, m_cnt);
    end
  end

  logic [6:0] legal_ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b1111111};

  initial begin
    reset = 1'b1; opcode = 7'd0; instrValid = 1'b0; memReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {13'd0, state}, 16'd0);
    chk("reset_count", retiredCount, 16'd0);
    chk("reset_pcwe", {15'd0, pcWriteEnable}, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {15'd0, instrReady}, 16'd1);

    // ALU: 1, 4, 0
    opcode = 7'b0110011; instrValid = 1'b1;
    @(negedge clk); instrValid = 1'b0;
    chk("alu_s1", {13'd0, state}, 16'd1);
    chk("alu_pcwe1", {15'd0, pcWriteEnable}, 16'd0);
    @(negedge clk);
    chk("alu_s2", {13'd0, state}, 16'd4);
    chk("alu_pcwe2", {15'd0, pcWriteEnable}, 16'd1);
    @(negedge clk);
    chk("alu_s3", {13'd0, state}, 16'd0);
    chk("alu_count", retiredCount, 16'd1);

    // Load with three wait cycles
    opcode = 7'b0000011; instrValid = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); instrValid = 1'b0;
      chk("load_wait", {13'd0, state}, 16'd2);
      memReady = (i == 3);
    end
    @(negedge clk); memReady = 1'b0;
    chk("load_pc", {13'd0, state}, 16'd4);
    @(negedge clk);
    chk("load_idle", {13'd0, state}, 16'd0);
    chk("load_count", retiredCount, 16'd2);

    // Store that times out
    opcode = 7'b0100011; instrValid = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); instrValid = 1'b0;
      chk("store_wait", {13'd0, state}, 16'd3);
      chk("store_no_to", {15'd0, memTimeout}, 16'd0);
    end
    @(negedge clk);
    chk("store_pc", {13'd0, state}, 16'd4);
    chk("store_to", {15'd0, memTimeout}, 16'd1);
    @(negedge clk);
    chk("store_idle", {13'd0, state}, 16'd0);
    chk("store_to_clear", {15'd0, memTimeout}, 16'd0);
    chk("store_count", retiredCount, 16'd3);

    // Illegal opcode
    opcode = 7'b1111111; instrValid = 1'b1;
    @(negedge clk); instrValid = 1'b0;
    chk("ill_state", {13'd0, state}, 16'd4);
    chk("ill_pulse", {15'd0, illegalInstr}, 16'd1);
    chk("ill_pcwe", {15'd0, pcWriteEnable}, 16'd1);
    @(negedge clk);
    chk("ill_idle", {13'd0, state}, 16'd0);
    chk("ill_clear", {15'd0, illegalInstr}, 16'd0);
    chk("ill_count", retiredCount, 16'd4);

    // Reset two cycles into a load
    opcode = 7'b0000011; instrValid = 1'b1; memReady = 1'b0;
    @(negedge clk); instrValid = 1'b0;
    chk("rst_load_s", {13'd0, state}, 16'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", {13'd0, state}, 16'd0);
    chk("rst_mid_count", retiredCount, 16'd0);
    chk("rst_mid_pcwe", {15'd0, pcWriteEnable}, 16'd0);

    // Reset dominates a same-cycle accept
    opcode = 7'b1100011; instrValid = 1'b1;
    @(negedge clk);
    chk("rst_dom_state", {13'd0, state}, 16'd0);
    reset = 1'b0; instrValid = 1'b0;
    @(negedge clk);
    chk("rst_dom_idle", {13'd0, state}, 16'd0);
    chk("rst_dom_ready", {15'd0, instrReady}, 16'd1);

    // Counter wrap via a forced preload
    @(posedge clk); #2;
    force dut.retired_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.retired_count;
    @(negedge clk);
    chk("wrap_pre", retiredCount, 16'hFFFF);
    opcode = 7'b1100011; instrValid = 1'b1;
    @(negedge clk); instrValid = 1'b0;
    chk("wrap_br", {13'd0, state}, 16'd4);
    @(negedge clk);
    chk("wrap_count", retiredCount, 16'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 299) == 0);
      instrValid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 11) < 10) opcode = legal_ops[$urandom_range(0, 9)];
      else                            opcode = 7'($urandom);
      memReady   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    reset = 1'b0; instrValid = 1'b0; memReady = 1'b0;
    repeat (25) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
